// File: rtl/tm1638_responder_if.sv
// tm1638_responder_if: serial LED&KEY bus between a TM1638-style master and
// the responder. The master drives clock, strobe and write data; the
// responder drives the key-read data bit and its output enable.
interface tm1638_responder_if;
    logic lk_clk;
    logic lk_stb;
    logic lk_dio_in;
    logic lk_dio_out;
    logic lk_dio_oe;

    modport master (
        output lk_clk,
        output lk_stb,
        output lk_dio_in,
        input  lk_dio_out,
        input  lk_dio_oe
    );

    modport slave (
        input  lk_clk,
        input  lk_stb,
        input  lk_dio_in,
        output lk_dio_out,
        output lk_dio_oe
    );
endinterface

// File: rtl/tm1638_responder.sv
// tm1638_responder: emulates the TM1638 LED&KEY serial protocol from the
// chip side. Bytes arrive LSB first on DIO, sampled on lk_clk rising edges
// while lk_stb is low. Display commands land in a 16-byte display RAM that
// the host reads through disp_addr/disp_data.
// Optional feature: define TM1638_KEY_READ_EN to enable key read-back
// (RDATA). Without it a read data command is ignored, DIO is never driven
// and the keys input is unused.
// All bus inputs are asynchronous to clk; clk must run at least 4x lk_clk.
module tm1638_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    tm1638_responder_if.slave   lk,
    input  logic [31:0]         keys,
    input  logic [3:0]          disp_addr,
    output logic [7:0]          disp_data,
    output logic                disp_on,
    output logic [2:0]          brightness,
    output logic                wr_strobe,
    output logic [3:0]          wr_addr,
    output logic                frame_err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        WDATA  = 3'd2,
        RDATA  = 3'd3,
        IGNORE = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_stb_sync;
    logic [SYNC_STAGES-1:0] r_dio_sync;
    logic                   r_clk_prev;
    logic                   r_stb_prev;

    // Synchronizer chains are deliberately left out of reset: they only
    // track the pins, and resetting them to a fixed level could fabricate a
    // strobe edge when rst is released in the middle of a transaction.
    always_ff @(posedge clk) begin
        r_clk_sync[0] <= lk.lk_clk;
        r_stb_sync[0] <= lk.lk_stb;
        r_dio_sync[0] <= lk.lk_dio_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            r_clk_sync[i] <= r_clk_sync[i-1];
            r_stb_sync[i] <= r_stb_sync[i-1];
            r_dio_sync[i] <= r_dio_sync[i-1];
        end
        r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
        r_stb_prev <= r_stb_sync[SYNC_STAGES-1];
    end

    logic w_clk_s;
    logic w_stb_s;
    logic w_dio_s;
    logic w_clk_rise;
    logic w_clk_fall;
    logic w_stb_rise;
    logic w_stb_fall;

    assign w_clk_s    = r_clk_sync[SYNC_STAGES-1];
    assign w_stb_s    = r_stb_sync[SYNC_STAGES-1];
    assign w_dio_s    = r_dio_sync[SYNC_STAGES-1];
    assign w_clk_rise =  w_clk_s & ~r_clk_prev;
    assign w_clk_fall = ~w_clk_s &  r_clk_prev;
    assign w_stb_rise =  w_stb_s & ~r_stb_prev;
    assign w_stb_fall = ~w_stb_s &  r_stb_prev;

    // ------------------------------------------------------------------
    // Protocol state
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic [3:0]  r_addr;
    logic        r_read;
    logic        r_fixed;
    logic        r_disp_on;
    logic [2:0]  r_brightness;
    logic        r_wr_strobe;
    logic [3:0]  r_wr_addr;
    logic        r_frame_err;
    logic [7:0]  r_ram [16];
    logic [7:0]  r_disp_data;

`ifdef TM1638_KEY_READ_EN
    logic [31:0] r_keys_sr;
    logic [4:0]  r_rd_cnt;
    logic        r_dio_out;
    logic        r_dio_oe;
`endif

    // A bit is taken only on a synced clock rise with the strobe still low;
    // a strobe rise in the same cycle wins because the stb branch is first.
    logic       w_bit;
    logic       w_byte_done;
    logic [7:0] w_byte;

    assign w_bit       = w_clk_rise & ~w_stb_s;
    assign w_byte_done = w_bit & (r_bit_cnt == 3'd7);
    assign w_byte      = {w_dio_s, r_shift[7:1]};

    // Main FSM: byte assembly, command decode, RAM writes and key read-out
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_bit_cnt    <= 3'd0;
            r_shift      <= 8'd0;
            r_addr       <= 4'd0;
            r_read       <= 1'b0;
            r_fixed      <= 1'b0;
            r_disp_on    <= 1'b0;
            r_brightness <= 3'd0;
            r_wr_strobe  <= 1'b0;
            r_wr_addr    <= 4'd0;
            r_frame_err  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_ram[i] <= 8'd0;
            end
`ifdef TM1638_KEY_READ_EN
            r_keys_sr    <= 32'd0;
            r_rd_cnt     <= 5'd0;
            r_dio_out    <= 1'b0;
            r_dio_oe     <= 1'b0;
`endif
        end else begin
            r_wr_strobe <= 1'b0;
            r_frame_err <= 1'b0;

            if (w_stb_rise) begin
                // End of transaction; a partly shifted byte is a framing error
                if ((r_state == CMD || r_state == WDATA) && r_bit_cnt != 3'd0)
                    r_frame_err <= 1'b1;
                r_state <= IDLE;
`ifdef TM1638_KEY_READ_EN
                r_dio_oe <= 1'b0;
`endif
            end else if (r_state == IDLE) begin
                if (w_stb_fall) begin
                    r_state   <= CMD;
                    r_bit_cnt <= 3'd0;
                end
            end else begin
                if (w_bit) begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    r_shift   <= w_byte;
                end

                case (r_state)
                    CMD: begin
                        if (w_byte_done) begin
                            case (w_byte[7:6])
                                2'b01: begin
                                    r_read  <= w_byte[1];
                                    r_fixed <= w_byte[2];
`ifdef TM1638_KEY_READ_EN
                                    if (w_byte[1]) begin
                                        r_state   <= RDATA;
                                        r_keys_sr <= keys;
                                        r_rd_cnt  <= 5'd0;
                                        r_dio_oe  <= 1'b1;
                                    end else begin
                                        r_state <= IGNORE;
                                    end
`else
                                    r_state <= IGNORE;
`endif
                                end
                                2'b10: begin
                                    r_disp_on    <= w_byte[3];
                                    r_brightness <= w_byte[2:0];
                                    r_state      <= IGNORE;
                                end
                                2'b11: begin
                                    r_addr  <= w_byte[3:0];
                                    r_state <= WDATA;
                                end
                                default: r_state <= IGNORE;
                            endcase
                        end
                    end

                    WDATA: begin
                        if (w_byte_done) begin
                            r_ram[r_addr] <= w_byte;
                            r_wr_strobe   <= 1'b1;
                            r_wr_addr     <= r_addr;
                            if (!r_fixed)
                                r_addr <= r_addr + 4'd1;
                        end
                    end

`ifdef TM1638_KEY_READ_EN
                    RDATA: begin
                        // Master samples on rising edges, so the next bit is
                        // put out on each falling edge
                        if (w_clk_fall && !w_stb_s) begin
                            r_dio_out <= r_keys_sr[0];
                            r_keys_sr <= {1'b0, r_keys_sr[31:1]};
                        end
                        if (w_bit) begin
                            if (r_rd_cnt == 5'd31) begin
                                r_state  <= IGNORE;
                                r_dio_oe <= 1'b0;
                            end else begin
                                r_rd_cnt <= r_rd_cnt + 5'd1;
                            end
                        end
                    end
`endif

                    default: ;
                endcase
            end
        end
    end

    // Registered display RAM read port; a same-cycle write shows next cycle
    always_ff @(posedge clk) begin
        if (rst)
            r_disp_data <= 8'd0;
        else
            r_disp_data <= r_ram[disp_addr];
    end

    assign disp_data  = r_disp_data;
    assign disp_on    = r_disp_on;
    assign brightness = r_brightness;
    assign wr_strobe  = r_wr_strobe;
    assign wr_addr    = r_wr_addr;
    assign frame_err  = r_frame_err;

`ifdef TM1638_KEY_READ_EN
    assign lk.lk_dio_out = r_dio_out;
    assign lk.lk_dio_oe  = r_dio_oe;

    // Read mode is kept as protocol state only; routing uses the command bit
    logic w_unused;
    assign w_unused = r_read;
`else
    assign lk.lk_dio_out = 1'b0;
    assign lk.lk_dio_oe  = 1'b0;

    logic w_unused;
    assign w_unused = ^{r_read, keys, w_clk_fall};
`endif

endmodule

// File: tb/tb_tm1638_responder.sv
// tb_tm1638_responder: bit-bangs the LED&KEY master protocol against the
// responder and compares RAM contents, write pulses, frame errors, display
// control and key read-back with a simple array-based model of the chip.
module tb_tm1638_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] keys = 32'd0;
    logic [3:0]  disp_addr = 4'd0;
    logic [7:0]  disp_data;
    logic        disp_on;
    logic [2:0]  brightness;
    logic        wr_strobe;
    logic [3:0]  wr_addr;
    logic        frame_err;

    tm1638_responder_if lk_if ();

    tm1638_responder #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .lk         (lk_if),
        .keys       (keys),
        .disp_addr  (disp_addr),
        .disp_data  (disp_data),
        .disp_on    (disp_on),
        .brightness (brightness),
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Observed write pulses and frame errors, collected away from the edge
    logic [3:0] wr_q[$];
    int         n_ferr = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_strobe) wr_q.push_back(wr_addr);
            if (frame_err) n_ferr++;
        end
    end

    // Reference model of the chip-visible state
    logic [7:0] m_ram [16];
    logic       m_on;
    logic [2:0] m_bri;
    logic [7:0] wq[$];
    int         wr_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic xfer_start();
        lk_if.lk_stb = 1'b0;
        tick(4);
    endtask

    task automatic xfer_end();
        lk_if.lk_stb = 1'b1;
        tick(6);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            lk_if.lk_clk    = 1'b0;
            lk_if.lk_dio_in = b[i];
            tick(4);
            lk_if.lk_clk    = 1'b1;
            tick(4);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8);
    endtask

    task automatic cmd1(input logic [7:0] b);
        xfer_start();
        send_byte(b);
        xfer_end();
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_ram[i] = 8'd0;
        m_on  = 1'b0;
        m_bri = 3'd0;
    endtask

    // Data command, then address set followed by the bytes held in wq
    task automatic write_seq(input logic [3:0] a0, input logic fixed, input string tag);
        logic [3:0] a;
        logic [3:0] exp_a[$];
        int         base;
        cmd1(fixed ? 8'h44 : 8'h40);
        base = wr_q.size();
        xfer_start();
        send_byte({4'hC, a0});
        a = a0;
        foreach (wq[i]) begin
            send_byte(wq[i]);
            m_ram[a] = wq[i];
            exp_a.push_back(a);
            if (!fixed) a = (a == 4'd15) ? 4'd0 : a + 4'd1;
        end
        xfer_end();
        chk($sformatf("%s_nwr", tag), wr_q.size() - base, exp_a.size());
        for (int i = 0; i < exp_a.size() && base + i < wr_q.size(); i++)
            chk($sformatf("%s_wraddr%0d", tag, i), wr_q[base + i], exp_a[i]);
        wr_seen = wr_q.size();
    endtask

    task automatic check_ram(input string tag);
        for (int i = 0; i < 16; i++) begin
            disp_addr = i[3:0];
            tick(1);
            chk($sformatf("%s_ram%0d", tag, i), disp_data, m_ram[i]);
        end
    endtask

    task automatic check_disp(input string tag);
        chk({tag, "_on"}, disp_on, m_on);
        chk({tag, "_bri"}, brightness, m_bri);
    endtask

    // Read command 0x42 then 32 master clocks; keys change after entry to
    // confirm the snapshot is taken at the command
    task automatic read_keys(input logic [31:0] k, input string tag);
        logic [31:0] got;
        logic [31:0] exp_k;
        logic        exp_oe;
        int          oe_bad;
`ifdef TM1638_KEY_READ_EN
        exp_k  = k;
        exp_oe = 1'b1;
`else
        exp_k  = 32'd0;
        exp_oe = 1'b0;
`endif
        keys = k;
        xfer_start();
        send_byte(8'h42);
        keys = $urandom;
        oe_bad = 0;
        got = 32'd0;
        for (int i = 0; i < 32; i++) begin
            lk_if.lk_clk = 1'b0;
            tick(4);
            got[i] = lk_if.lk_dio_out;
            if (lk_if.lk_dio_oe !== exp_oe) oe_bad++;
            lk_if.lk_clk = 1'b1;
            tick(4);
        end
        for (int b = 0; b < 4; b++)
            chk($sformatf("%s_byte%0d", tag, b), got[8*b +: 8], exp_k[8*b +: 8]);
        chk({tag, "_oe_during"}, oe_bad, 0);
        chk({tag, "_oe_after32"}, lk_if.lk_dio_oe, 1'b0);
        xfer_end();
        chk({tag, "_oe_after_stb"}, lk_if.lk_dio_oe, 1'b0);
    endtask

    initial begin
        int          ferr0;
        logic [3:0]  r4;
        lk_if.lk_clk    = 1'b1;
        lk_if.lk_stb    = 1'b1;
        lk_if.lk_dio_in = 1'b0;
        model_clear();

        // Reset state
        rst = 1'b1;
        tick(4);
        rst = 1'b0;
        tick(1);
        chk("rst_disp_data", disp_data, 8'd0);
        check_disp("rst");
        chk("rst_wr_strobe", wr_strobe, 1'b0);
        chk("rst_wr_addr", wr_addr, 4'd0);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_oe", lk_if.lk_dio_oe, 1'b0);
        chk("rst_dout", lk_if.lk_dio_out, 1'b0);
        check_ram("rst");

        // Auto-increment write
        wq = {8'h3F, 8'h06};
        write_seq(4'd0, 1'b0, "auto");
        check_ram("auto");

        // Fixed address write stays on 15
        wq = {8'hAA, 8'h55};
        write_seq(4'd15, 1'b1, "fixed");
        check_ram("fixed");

        // Auto-increment wraps 15 -> 0
        wq = {};
        for (int i = 0; i < 3; i++) wq.push_back(8'($urandom));
        write_seq(4'd14, 1'b0, "wrap");
        check_ram("wrap");

        // Display control
        cmd1(8'h8C); m_on = 1'b1; m_bri = 3'd4;
        check_disp("ctl8c");
        cmd1(8'h80); m_on = 1'b0; m_bri = 3'd0;
        check_disp("ctl80");
        for (int i = 0; i < 3; i++) begin
            r4 = 4'($urandom_range(0, 15));
            cmd1({4'h8, r4});
            m_on = r4[3]; m_bri = r4[2:0];
            check_disp($sformatf("ctlrnd%0d", i));
        end

        // Randomized write bursts
        for (int t = 0; t < 4; t++) begin
            wq = {};
            for (int i = 0; i < $urandom_range(1, 5); i++) wq.push_back(8'($urandom));
            write_seq(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                      $sformatf("rnd%0d", t));
        end
        check_ram("rnd");

        // Key read-back
        read_keys(32'h87654321, "keys");
        read_keys($urandom, "keysrnd");

        // Partial data byte: frame error, no write, next command still works
        ferr0 = n_ferr;
        cmd1(8'h40);
        wr_seen = wr_q.size();
        xfer_start();
        send_byte(8'hC3);
        send_byte(8'h11);
        send_bits(8'hFF, 5);
        xfer_end();
        m_ram[3] = 8'h11;
        chk("abort_ferr", n_ferr - ferr0, 1);
        chk("abort_nwr", wr_q.size() - wr_seen, 1);
        if (wr_q.size() > wr_seen) chk("abort_wraddr", wr_q[wr_seen], 4'd3);
        check_ram("abort");
        cmd1(8'h8A); m_on = 1'b1; m_bri = 3'd2;
        check_disp("after_abort");

        // Partial command byte also flags a frame error and changes nothing
        ferr0 = n_ferr;
        xfer_start();
        send_bits(8'h8F, 3);
        xfer_end();
        chk("cmdabort_ferr", n_ferr - ferr0, 1);
        check_disp("cmdabort");

        // Clock activity with strobe high is ignored; full byte has no ferr
        ferr0 = n_ferr;
        for (int i = 0; i < 8; i++) begin
            lk_if.lk_dio_in = 1'b1;
            lk_if.lk_clk = 1'b0; tick(4);
            lk_if.lk_clk = 1'b1; tick(4);
        end
        cmd1(8'h8B); m_on = 1'b1; m_bri = 3'd3;
        check_disp("stbhigh");
        chk("stbhigh_ferr", n_ferr - ferr0, 0);

        // Reset in mid-transaction: no frame error, waits for a fresh strobe
        cmd1(8'h40);
        xfer_start();
        send_byte(8'hC0);
        send_bits(8'h77, 3);
        ferr0 = n_ferr;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        model_clear();
        check_disp("midrst");
        xfer_end();
        chk("midrst_ferr", n_ferr - ferr0, 0);
        wq = {8'($urandom), 8'($urandom)};
        write_seq(4'd5, 1'b0, "postrst");
        check_ram("postrst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tm1638_responder.md
TM1638_RESPONDER -- requirements
Module: tm1638_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on lk_clk, lk_stb, lk_dio_in.
REQ-002 SHALL have port clk  input  1  sole clock for all logic.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port lk_clk  input  1  serial clock from the LED&KEY master.
REQ-005 SHALL have port lk_stb  input  1  strobe from the master; low means a transaction is active.
REQ-006 SHALL have port lk_dio_in  input  1  serial data from the master.
REQ-007 SHALL have port lk_dio_out  output  1  key-read data bit.
REQ-008 SHALL have port lk_dio_oe  output  1  DIO output enable.
REQ-009 SHALL have port keys  input  32  key scan state; byte n is keys[8n+7:8n].
REQ-010 SHALL have port disp_addr  input  4  display RAM read address.
REQ-011 SHALL have port disp_data  output  8  display RAM read data.
REQ-012 SHALL have port disp_on  output  1  display enable from the control command.
REQ-013 SHALL have port brightness  output  3  brightness from the control command.
REQ-014 SHALL have port wr_strobe  output  1  one-cycle pulse per display byte written.
REQ-015 SHALL have port wr_addr  output  4  address of the last written byte.
REQ-016 SHALL have port frame_err  output  1  one-cycle pulse on an aborted partial byte.

Function
REQ-017 SHALL synchronize lk_clk, lk_stb and lk_dio_in through SYNC_STAGES flops and edge-detect the synchronized lk_clk and lk_stb; correct operation requires clk >= 4x lk_clk.
REQ-018 SHALL use the states IDLE, CMD, WDATA, RDATA and IGNORE; a synced lk_stb falling edge moves the block from IDLE to CMD and clears the bit counter.
REQ-019 SHALL sample DIO on each synced lk_clk rising edge while lk_stb is low, LSB first; 8 samples complete a byte, and the bit counter wraps 7->0.
REQ-020 SHALL decode the CMD byte in the cycle it completes: [7:6]=01 is a data command (latch read=bit1, fixed=bit2; read -> RDATA, else -> IGNORE); 10 is display control (disp_on=bit3, brightness=bits2:0; -> IGNORE); 11 is address set (addr=bits3:0; -> WDATA); 00 -> IGNORE.
REQ-021 SHALL, in WDATA, write each completed byte to ram[addr], pulse wr_strobe, set wr_addr=addr, and then increment addr modulo 16 (15->0) unless fixed mode is set.
REQ-022 SHALL, on RDATA entry, snapshot keys into a 32-bit shift register and drive lk_dio_oe=1.
REQ-023 SHALL, in RDATA, present the next snapshot bit on lk_dio_out at each synced lk_clk falling edge, starting with bit 0 on the first falling edge after entry.
REQ-024 SHALL, in RDATA, drop lk_dio_oe and go to IGNORE after 32 bits.
REQ-025 SHALL, on a synced lk_stb rising edge in any state, return to IDLE and clear lk_dio_oe in the same cycle.
REQ-026 SHALL, on that lk_stb rising edge in CMD or WDATA with the bit counter nonzero, discard the partial byte and pulse frame_err.
REQ-027 SHALL let an lk_stb rising edge coincident with an lk_clk rising edge take precedence, so that the coincident bit is discarded.
REQ-028 SHALL keep read/fixed mode across transactions until the next data command.
REQ-029 SHALL register disp_data = ram[disp_addr] with 1-cycle latency; a same-cycle write to that address returns the old data.
REQ-030 SHALL ignore lk_clk edges while lk_stb is high.

Reset
REQ-031 SHALL, on rst, set the state to IDLE, clear all 16 RAM bytes, clear read/fixed mode (write, auto-increment), set addr=0, and drive disp_on=0, brightness=0, lk_dio_out=0, lk_dio_oe=0, wr_strobe=0, wr_addr=0, frame_err=0 and disp_data=0 the next cycle.
REQ-032 SHALL let rst mid-transaction abort the transaction without a frame_err pulse; the block then waits for a fresh lk_stb falling edge.

Configuration
REQ-033 SHALL, with TM1638_KEY_READ_EN defined, implement RDATA as specified.
REQ-034 SHALL, without TM1638_KEY_READ_EN, send a read data command to IGNORE, hold lk_dio_oe and lk_dio_out at 0, and leave keys unused.

Verification
REQ-035 SHALL cover: transaction 0x40, then 0xC0,0x3F,0x06 -> ram[0]=0x3F, ram[1]=0x06, two wr_strobe pulses, wr_addr 0 then 1.
REQ-036 SHALL cover: 0x44, then 0xCF,0xAA,0x55 -> ram[15]=0x55 (fixed mode, no wrap), ram[0] unchanged.
REQ-037 SHALL cover: 0x40, then 0xCE with 3 bytes -> writes to 14, 15, 0 (wrap).
REQ-038 SHALL cover: 0x8C -> disp_on=1, brightness=4; 0x80 -> disp_on=0.
REQ-039 SHALL cover: keys=0x87654321, 0x42 then 32 clocks -> master samples 0x21,0x43,0x65,0x87 with oe=1; oe=0 after lk_stb rises (without the macro, oe stays 0).
REQ-040 SHALL cover: lk_stb raised after 5 bits of a WDATA byte -> frame_err pulse, no RAM write, next transaction decodes normally.
